// File: rtl/commu_pull_if.sv
// Handshake bundle between the packet-pull engine, the word receiver and the packet buffer.
// The slave modport is the pull engine; the master modport is whoever drives it.
interface commu_pull_if;
  logic        fire_pull;
  logic        done_pull;
  logic        err_pull;
  logic        fire_rx;
  logic [15:0] data_rx;
  logic        done_rx;
  logic        buf_wr;
  logic [7:0]  buf_d;
  logic        buf_frm;
  logic [15:0] len_pkg;

  modport master (
    output fire_pull, fire_rx, data_rx, len_pkg,
    input  done_pull, err_pull, done_rx, buf_wr, buf_d, buf_frm
  );

  modport slave (
    input  fire_pull, fire_rx, data_rx, len_pkg,
    output done_pull, err_pull, done_rx, buf_wr, buf_d, buf_frm
  );
endinterface

// File: rtl/commu_pull.sv
// Receive-side packet pull: gathers len_pkg/2 words from the word receiver and writes them
// into the packet buffer high byte first, with a per-word stall timeout.
module commu_pull #(
  parameter int unsigned          TO_W   = 24,
  parameter logic [TO_W-1:0]      TO_DEF = 24'hFFFFFF
) (
  input logic         clk_sys,
  input logic         rst,
  commu_pull_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StWrh,
    StWrl,
    StAck,
    StNext,
    StDone,
    StErr
  } state_e;

  localparam logic [TO_W-1:0] ToLast = TO_DEF - TO_W'(1);

  state_e          state_q, state_d;
  logic [15:0]     cnt_word_q, cnt_word_d;
  logic [15:0]     len_w_q, len_w_d;
  logic [15:0]     data_q, data_d;
  logic [TO_W-1:0] cnt_to_q, cnt_to_d;

  logic       done_pull;
  logic       err_pull;
  logic       done_rx;
  logic       buf_wr;
  logic [7:0] buf_d;
  logic       buf_frm;

  always_comb begin
    state_d    = state_q;
    cnt_word_d = cnt_word_q;
    len_w_d    = len_w_q;
    data_d     = data_q;
    cnt_to_d   = cnt_to_q;
    done_pull  = 1'b0;
    err_pull   = 1'b0;
    done_rx    = 1'b0;
    buf_wr     = 1'b0;
    buf_d      = 8'h00;
    buf_frm    = (state_q != StIdle);

    unique case (state_q)
      StIdle: begin
        // A word offered alongside the start pulse is dropped on purpose.
        if (bus.fire_pull) begin
          len_w_d = {1'b0, bus.len_pkg[15:1]};
          state_d = (bus.len_pkg[15:1] == 15'd0) ? StDone : StWait;
        end
      end
      StWait: begin
        if (bus.fire_rx) begin
          data_d   = bus.data_rx;
          cnt_to_d = '0;
          state_d  = StWrh;
        end else begin
          if (cnt_to_q != '1) begin
            cnt_to_d = cnt_to_q + 1'b1;
          end
          if ((TO_DEF != '0) && (cnt_to_q == ToLast)) begin
            state_d = StErr;
          end
        end
      end
      StWrh: begin
        buf_wr  = 1'b1;
        buf_d   = data_q[15:8];
        state_d = StWrl;
      end
      StWrl: begin
        buf_wr     = 1'b1;
        buf_d      = data_q[7:0];
        cnt_word_d = cnt_word_q + 16'd1;
        state_d    = StAck;
      end
      StAck: begin
        done_rx = 1'b1;
        state_d = StNext;
      end
      StNext: begin
        state_d = (cnt_word_q == len_w_q) ? StDone : StWait;
      end
      StDone: begin
        done_pull  = 1'b1;
        cnt_word_d = '0;
        state_d    = StIdle;
      end
      StErr: begin
        done_pull  = 1'b1;
        err_pull   = 1'b1;
        cnt_word_d = '0;
        cnt_to_d   = '0;
        state_d    = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_word_q <= '0;
      len_w_q    <= '0;
      data_q     <= '0;
      cnt_to_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_word_q <= cnt_word_d;
      len_w_q    <= len_w_d;
      data_q     <= data_d;
      cnt_to_q   <= cnt_to_d;
    end
  end

  assign bus.done_pull = done_pull;
  assign bus.err_pull  = err_pull;
  assign bus.done_rx   = done_rx;
  assign bus.buf_wr    = buf_wr;
  assign bus.buf_d     = buf_d;
  assign bus.buf_frm   = buf_frm;

endmodule
